alu_issue: RTL
==============

Name: alu_issue

Overview:
- Sequential front-end for the single-cycle combinational ALU.
- Accepts decoded RISC-V integer requests (opcode, funct3, funct7[5], rs1, rs2, imm) over a valid/ready handshake.
- Produces the ALU's 4-bit alu_control, registers the operands into the ALU, captures result and zero flag, and returns them through a small response FIFO with valid/ready backpressure.
- It is the producer side of the ALU interface: encoder of alu_control and driver of operand_a/operand_b.

Parameters:
- DEPTH, 2, response FIFO entries; legal values 2..8.
- XLEN, 32, operand and result width.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_opcode  in  7  instruction opcode field
- req_funct3  in  3  funct3 field
- req_funct7_5  in  1  instruction bit 30
- req_rs1  in  XLEN  source operand 1
- req_rs2  in  XLEN  source operand 2
- req_imm  in  XLEN  sign-extended immediate
- alu_a  out  XLEN  registered operand_a to ALU
- alu_b  out  XLEN  registered operand_b to ALU
- alu_control  out  4  registered op code to ALU
- alu_result  in  XLEN  ALU result (combinational from alu_a/alu_b/alu_control)
- alu_zero  in  1  ALU zero flag
- rsp_valid  out  1  FIFO head valid
- rsp_ready  in  1  consumer accepts head
- rsp_result  out  XLEN  head result
- rsp_zero  out  1  head zero flag
- rsp_illegal  out  1  head request was not an ALU op

Behaviour:
- Reset: synchronous, active-high; clk is the only clock. All outputs and state clear on the reset edge. Values after reset: req_ready=1, alu_a=0, alu_b=0, alu_control=4'b0000, rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_illegal=0, FIFO count=0, in-flight flag=0.
- alu_control encoding:
  - 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU
  - 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND
- Decode, opcode 0110011 (R-type):
  - alu_b=rs2.
  - funct3 map: 000→ADD, or SUB if funct7_5=1; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101→SRL, or SRA if funct7_5=1; 110 OR; 111 AND.
- Decode, opcode 0010011 (I-type): alu_b=imm; same map, except funct3=000 is always ADD (ignore funct7_5). funct7_5 selects SRA only for funct3=101.
- Any other opcode: illegal.
  - ALU registers are not updated.
  - Entry pushed with result=0, zero=0, illegal=1.
- Accept: a transfer occurs when req_valid && req_ready.
  - Cycle N: accept.
  - Edge N→N+1: alu_a/alu_b/alu_control load; in-flight=1.
  - Edge N+1→N+2: alu_result/alu_zero push into FIFO.
  - rsp_valid=1 from cycle N+2.
- Throughput: one request per cycle, back-to-back, with no bubbles while space exists.
- Flow control:
  - req_ready = (count + in-flight) < DEPTH.
  - A pop in the same cycle does not raise req_ready that cycle (no combinational path rsp_ready→req_ready).
- Illegal requests follow the same timing and slot accounting, so the response order always equals request order.
- FIFO:
  - Circular buffer with wrapping read/write pointers and count.
  - Simultaneous push and pop with count>0: count unchanged.
  - Push when full cannot occur, by construction; assert in simulation.
  - Pop when empty is ignored.
- rsp_* outputs come from the head entry registers; they hold stable while rsp_valid && !rsp_ready.
- Reset mid-operation: the in-flight op and all FIFO contents are discarded; no response is produced for them.
- Arithmetic is performed by the ALU; this block adds no width extension.

Optional Feature:
- Macro ALU_ISSUE_OPCOUNT_EN.
- When defined:
  - Adds output op_count (32 bits): number of legal requests accepted since reset.
  - Adds output illegal_count (16 bits): number of illegal requests accepted since reset.
  - Both clear on rst and wrap modulo 2^width.
- When undefined: neither port nor counters exist; all other behaviour is identical.

Test Plan:
- After reset, R-type ADD with rs1=11, rs2=12 → alu_control=0000, alu_a=11, alu_b=12 at N+1; rsp_result=23, rsp_zero=0 at N+2.
- R-type SUB (funct7_5=1) with 20, 15 → rsp_result=5; then SUB with 7, 7 → rsp_result=0, rsp_zero=1.
- I-type AND with rs1=0x0F0F, imm=0xF0F0, followed back-to-back by R-type OR on the same operands → responses in order: 0x00000000 with zero=1, then 0x0000FFFF; two accepts in consecutive cycles.
- Backpressure: hold rsp_ready=0 and issue 3 requests with DEPTH=2 → req_ready=0 after 2 accepts; head holds steady; raise rsp_ready → 2 pops, then the third request is accepted.
- Opcode 0000011 → rsp_illegal=1, result=0, alu_control unchanged; with ALU_ISSUE_OPCOUNT_EN defined, illegal_count increments to 1 and op_count is unchanged.
- Assert rst at cycle N+1 of an in-flight ADD → no rsp_valid afterward; all outputs at reset values the next cycle.

Source files
------------

// File: rtl/alu_issue.sv
// alu_issue: sequential front-end for a single-cycle combinational ALU.
// Decodes RV32I R-type/I-type requests into alu_control, registers the operands
// into the ALU, captures result/zero one cycle later and queues them in a
// DEPTH-entry response FIFO. A request accepted in cycle N is visible on rsp_* from N+2.
// Ports:
//   clk, rst                      single clock, synchronous active-high reset
//   req_valid/req_ready           request handshake; ready = (count + in-flight) < DEPTH
//   req_opcode/funct3/funct7_5    decoded instruction fields
//   req_rs1/req_rs2/req_imm       operands (imm already sign-extended)
//   alu_a/alu_b/alu_control       registered drive into the ALU
//   alu_result/alu_zero           combinational ALU response
//   rsp_valid/rsp_ready           response handshake, head-of-FIFO
//   rsp_result/rsp_zero/rsp_illegal  head entry contents
// Optional: define ALU_ISSUE_OPCOUNT_EN to add op_count (legal accepts) and
// illegal_count (illegal accepts) outputs.
module alu_issue #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [6:0]      req_opcode,
  input  logic [2:0]      req_funct3,
  input  logic            req_funct7_5,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [XLEN-1:0] req_imm,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_control,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_result,
  output logic            rsp_zero,
  output logic            rsp_illegal
`ifdef ALU_ISSUE_OPCOUNT_EN
  ,
  output logic [31:0]     op_count,
  output logic [15:0]     illegal_count
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  localparam logic [3:0] C_ADD  = 4'b0000;
  localparam logic [3:0] C_SUB  = 4'b0001;
  localparam logic [3:0] C_SLL  = 4'b0010;
  localparam logic [3:0] C_SLT  = 4'b0011;
  localparam logic [3:0] C_SLTU = 4'b0100;
  localparam logic [3:0] C_XOR  = 4'b0101;
  localparam logic [3:0] C_SRL  = 4'b0110;
  localparam logic [3:0] C_SRA  = 4'b0111;
  localparam logic [3:0] C_OR   = 4'b1000;
  localparam logic [3:0] C_AND  = 4'b1001;

  logic            dec_legal;
  logic            dec_use_imm;
  logic [3:0]      dec_ctrl;
  logic            accept;
  logic            inflight;
  logic            inflight_illegal;
  logic            push;
  logic            pop;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW:0]     occ;
  logic [XLEN-1:0] res_mem [DEPTH];
  logic            zero_mem [DEPTH];
  logic            ill_mem [DEPTH];

  always_comb begin
    dec_legal   = 1'b1;
    dec_use_imm = 1'b0;
    dec_ctrl    = C_ADD;
    if (req_opcode == OP_I) begin
      dec_use_imm = 1'b1;
    end else if (req_opcode != OP_R) begin
      dec_legal = 1'b0;
    end
    case (req_funct3)
      3'b000:  dec_ctrl = (req_opcode == OP_R && req_funct7_5) ? C_SUB : C_ADD;
      3'b001:  dec_ctrl = C_SLL;
      3'b010:  dec_ctrl = C_SLT;
      3'b011:  dec_ctrl = C_SLTU;
      3'b100:  dec_ctrl = C_XOR;
      3'b101:  dec_ctrl = req_funct7_5 ? C_SRA : C_SRL;
      3'b110:  dec_ctrl = C_OR;
      default: dec_ctrl = C_AND;
    endcase
  end

  // The in-flight slot is reserved at accept time, so the FIFO can never be
  // pushed while full. Ready deliberately ignores a same-cycle pop.
  assign occ       = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign req_ready = occ < (CW + 1)'(DEPTH);
  assign accept    = req_valid && req_ready;
  assign push      = inflight;
  assign pop       = rsp_ready && (count != '0);

  assign rsp_valid   = (count != '0);
  assign rsp_result  = res_mem[rd_ptr];
  assign rsp_zero    = zero_mem[rd_ptr];
  assign rsp_illegal = ill_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a            <= '0;
      alu_b            <= '0;
      alu_control      <= C_ADD;
      inflight         <= 1'b0;
      inflight_illegal <= 1'b0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        res_mem[i]  <= '0;
        zero_mem[i] <= 1'b0;
        ill_mem[i]  <= 1'b0;
      end
    end else begin
      inflight         <= accept;
      inflight_illegal <= accept && !dec_legal;
      // Illegal requests leave the ALU drive untouched.
      if (accept && dec_legal) begin
        alu_a       <= req_rs1;
        alu_b       <= dec_use_imm ? req_imm : req_rs2;
        alu_control <= dec_ctrl;
      end
      if (push) begin
        res_mem[wr_ptr]  <= inflight_illegal ? '0 : alu_result;
        zero_mem[wr_ptr] <= inflight_illegal ? 1'b0 : alu_zero;
        ill_mem[wr_ptr]  <= inflight_illegal;
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef ALU_ISSUE_OPCOUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count      <= '0;
      illegal_count <= '0;
    end else if (accept) begin
      if (dec_legal) op_count      <= op_count + 32'd1;
      else           illegal_count <= illegal_count + 16'd1;
    end
  end
`endif

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && count == CW'(DEPTH)));

endmodule
